// File: rtl/flapjack_console_pkg.sv
// flapjack_console_pkg: shared types and constants for the console controller.
//   state_e         - controller FSM states
//   CC_*            - control codes recognised when in_chr[8] == 0
//   CHR_BLANK_DEF   - default glyph written by row/screen clears
package flapjack_console_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPut,
        StClearRow,
        StClearAll
    } state_e;

    localparam logic [8:0] CC_BS = 9'h008;
    localparam logic [8:0] CC_LF = 9'h00A;
    localparam logic [8:0] CC_FF = 9'h00C;
    localparam logic [8:0] CC_CR = 9'h00D;

    localparam logic [8:0] CHR_BLANK_DEF = 9'h020;

endpackage

// File: rtl/flapjack_console.sv
// flapjack_console: character-stream console that drives the textmode write port.
// Accepts one character per valid/ready transfer, keeps a hardware cursor, interprets
// BS/LF/FF/CR and issues row or full-screen clears as bursts of write strobes.
// Ports:
//   clk_sys, reset          - clock, synchronous active-high reset
//   in_chr/in_valid/in_ready - character input handshake
//   char_x/char_y/char_chr/char_str - registered textmode write port
//   cursor_x/cursor_y       - cursor position (valid while in_ready is high)
//   busy                    - controller is not idle
module flapjack_console
    import flapjack_console_pkg::*;
#(
    parameter int unsigned COLS           = 80,
    parameter int unsigned ROWS           = 30,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [8:0]  CHR_BLANK      = CHR_BLANK_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [8:0] in_chr,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [6:0] char_x,
    output logic [5:0] char_y,
    output logic [8:0] char_chr,
    output logic       char_str,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic       busy
);

    localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [XW-1:0] XMax = XW'(COLS - 1);
    localparam logic [YW-1:0] YMax = YW'(ROWS - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic [XW-1:0] cnt_x_q, cnt_x_d;
    logic [YW-1:0] cnt_y_q, cnt_y_d;
    logic [6:0]    char_x_q, char_x_d;
    logic [5:0]    char_y_q, char_y_d;
    logic [8:0]    char_chr_q, char_chr_d;
    logic          char_str_q, char_str_d;
    logic [YW-1:0] next_row;

    // Wrap to the top row instead of scrolling.
    assign next_row = (cur_y_q == YMax) ? '0 : cur_y_q + YW'(1);

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cnt_x_d    = cnt_x_q;
        cnt_y_d    = cnt_y_q;
        char_x_d   = char_x_q;
        char_y_d   = char_y_q;
        char_chr_d = char_chr_q;
        char_str_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Control codes all have bit 8 clear, so a full 9-bit match
                    // already excludes in_chr[8] == 1.
                    case (in_chr)
                        CC_LF: begin
                            cur_x_d    = '0;
                            cur_y_d    = next_row;
                            cnt_x_d    = '0;
                            char_str_d = 1'b1;
                            char_x_d   = '0;
                            char_y_d   = 6'(next_row);
                            char_chr_d = CHR_BLANK;
                            state_d    = StClearRow;
                        end
                        CC_CR: cur_x_d = '0;
                        CC_BS: begin
                            if (cur_x_q != '0) cur_x_d = cur_x_q - XW'(1);
                        end
                        CC_FF: begin
                            cur_x_d    = '0;
                            cur_y_d    = '0;
                            cnt_x_d    = '0;
                            cnt_y_d    = '0;
                            char_str_d = 1'b1;
                            char_x_d   = '0;
                            char_y_d   = '0;
                            char_chr_d = CHR_BLANK;
                            state_d    = StClearAll;
                        end
                        default: begin
                            // Glyph strobe appears in the PUT cycle.
                            char_str_d = 1'b1;
                            char_x_d   = 7'(cur_x_q);
                            char_y_d   = 6'(cur_y_q);
                            char_chr_d = in_chr;
                            state_d    = StPut;
                        end
                    endcase
                end
            end
            StPut: begin
                if (cur_x_q == XMax) begin
                    cur_x_d    = '0;
                    cur_y_d    = next_row;
                    cnt_x_d    = '0;
                    char_str_d = 1'b1;
                    char_x_d   = '0;
                    char_y_d   = 6'(next_row);
                    char_chr_d = CHR_BLANK;
                    state_d    = StClearRow;
                end else begin
                    cur_x_d = cur_x_q + XW'(1);
                    state_d = StIdle;
                end
            end
            StClearRow: begin
                // cnt_x_q is the column of the strobe currently on the port.
                if (cnt_x_q == XMax) begin
                    state_d = StIdle;
                end else begin
                    cnt_x_d    = cnt_x_q + XW'(1);
                    char_str_d = 1'b1;
                    char_x_d   = 7'(cnt_x_d);
                    char_chr_d = CHR_BLANK;
                end
            end
            StClearAll: begin
                char_chr_d = CHR_BLANK;
                if (!char_str_q) begin
                    // Entered from reset: no strobe has been issued yet.
                    cnt_x_d    = '0;
                    cnt_y_d    = '0;
                    char_str_d = 1'b1;
                end else if (cnt_x_q == XMax) begin
                    if (cnt_y_q == YMax) begin
                        state_d = StIdle;
                    end else begin
                        cnt_x_d    = '0;
                        cnt_y_d    = cnt_y_q + YW'(1);
                        char_str_d = 1'b1;
                    end
                end else begin
                    cnt_x_d    = cnt_x_q + XW'(1);
                    char_str_d = 1'b1;
                end
                if (char_str_d) begin
                    char_x_d = 7'(cnt_x_d);
                    char_y_d = 6'(cnt_y_d);
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? StClearAll : StIdle;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            cnt_x_q    <= '0;
            cnt_y_q    <= '0;
            char_x_q   <= '0;
            char_y_q   <= '0;
            char_chr_q <= '0;
            char_str_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cnt_x_q    <= cnt_x_d;
            cnt_y_q    <= cnt_y_d;
            char_x_q   <= char_x_d;
            char_y_q   <= char_y_d;
            char_chr_q <= char_chr_d;
            char_str_q <= char_str_d;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign char_x   = char_x_q;
    assign char_y   = char_y_q;
    assign char_chr = char_chr_q;
    assign char_str = char_str_q;
    assign cursor_x = 7'(cur_x_q);
    assign cursor_y = 6'(cur_y_q);

endmodule

// File: tb/tb_flapjack_console.sv
// tb_flapjack_console: directed self-checking bench for flapjack_console (80x30).
module tb_flapjack_console;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [8:0] in_chr;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] char_x;
    logic [5:0] char_y;
    logic [8:0] char_chr;
    logic       char_str;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_cyc = 0;

    typedef struct {
        logic [6:0] x;
        logic [5:0] y;
        logic [8:0] chr;
        int         cyc;
    } strobe_t;

    strobe_t sq[$];

    flapjack_console #(
        .COLS(80),
        .ROWS(30),
        .CLEAR_ON_RESET(1),
        .CHR_BLANK(9'h020)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .in_chr  (in_chr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .char_x  (char_x),
        .char_y  (char_y),
        .char_chr(char_chr),
        .char_str(char_str),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Record every write strobe with the cycle it appeared in.
    always @(negedge clk_sys) begin
        if (char_str) begin
            strobe_t s;
            s.x = char_x;
            s.y = char_y;
            s.chr = char_chr;
            s.cyc = cyc;
            sq.push_back(s);
        end
    end

    task automatic send(input logic [8:0] c);
        in_chr   = c;
        in_valid = 1'b1;
        @(posedge clk_sys);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_sys);
            if (in_ready) begin
                ok = 1'b1;
                ready_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        int bad;
        reset = 1'b1;
        in_valid = 1'b0;
        in_chr = '0;
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (char_str !== 1'b0 || char_x !== 7'd0 || char_y !== 6'd0 || char_chr !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: str=%b x=%0d y=%0d chr=%h, want 0 0 0 000",
                     char_str, char_x, char_y, char_chr);
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: cur=(%0d,%0d) rdy=%b busy=%b, want (0,0) 0 1",
                     cursor_x, cursor_y, in_ready, busy);
        end
        sq.delete();
        wait_ready(3000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_clear_timeout: in_ready=%b, want 1 within 3000 cycles", in_ready);
        end
        checks++;
        if (sq.size() != 2400) begin
            errors++;
            $display("FAIL reset_clear_count: got %0d strobes, want 2400", sq.size());
        end
        bad = 0;
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].x != 7'(i % 80) || sq[i].y != 6'(i / 80) || sq[i].chr != 9'h020
                || (i > 0 && sq[i].cyc != sq[i-1].cyc + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_clear_order: %0d bad strobes, want 0", bad);
        end
        checks++;
        if (sq.size() == 0 || ready_cyc != sq[sq.size()-1].cyc + 1) begin
            errors++;
            $display("FAIL reset_ready_timing: ready cycle %0d, want last strobe cycle + 1",
                     ready_cyc);
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL reset_cursor: (%0d,%0d), want (0,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_single_char;
        bit ok;
        sq.delete();
        send(9'h041);
        @(negedge clk_sys);
        checks++;
        if (char_str !== 1'b1 || char_x !== 7'd0 || char_y !== 6'd0 || char_chr !== 9'h041
            || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL char_a_strobe: str=%b x=%0d y=%0d chr=%h rdy=%b, want 1 0 0 041 0",
                     char_str, char_x, char_y, char_chr, in_ready);
        end
        @(negedge clk_sys);
        checks++;
        if (in_ready !== 1'b1 || cursor_x !== 7'd1 || cursor_y !== 6'd0 || sq.size() != 1) begin
            errors++;
            $display("FAIL char_a_after: rdy=%b cur=(%0d,%0d) strobes=%0d, want 1 (1,0) 1",
                     in_ready, cursor_x, cursor_y, sq.size());
        end
    endtask

    task automatic test_row_fill;
        bit ok;
        bit all_ok;
        int bad;
        all_ok = 1'b1;
        send(9'h00D);
        @(negedge clk_sys);
        sq.delete();
        for (int i = 0; i < 80; i++) begin
            send(9'(9'h030 + (i % 10)));
            wait_ready(200, ok);
            if (!ok) all_ok = 1'b0;
        end
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL row_fill_timeout: in_ready stayed low, want 1");
        end
        checks++;
        if (sq.size() != 160) begin
            errors++;
            $display("FAIL row_fill_count: got %0d strobes, want 160", sq.size());
        end
        bad = 0;
        for (int i = 0; i < sq.size() && i < 160; i++) begin
            if (i < 80) begin
                if (sq[i].x != 7'(i) || sq[i].y != 6'd0 || sq[i].chr != 9'(9'h030 + (i % 10)))
                    bad++;
                if (i > 0 && sq[i].cyc != sq[i-1].cyc + 2) bad++;
            end else begin
                if (sq[i].x != 7'(i - 80) || sq[i].y != 6'd1 || sq[i].chr != 9'h020) bad++;
                if (sq[i].cyc != sq[i-1].cyc + 1) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL row_fill_order: %0d bad strobes, want 0", bad);
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd1) begin
            errors++;
            $display("FAIL row_fill_cursor: (%0d,%0d), want (0,1)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_lf_wrap;
        bit ok;
        bit all_ok;
        int bad;
        int t1;
        all_ok = 1'b1;
        for (int i = 0; i < 28; i++) begin
            send(9'h00A);
            wait_ready(200, ok);
            if (!ok) all_ok = 1'b0;
        end
        checks++;
        if (!all_ok || cursor_x !== 7'd0 || cursor_y !== 6'd29) begin
            errors++;
            $display("FAIL lf_to_bottom: cur=(%0d,%0d) ok=%b, want (0,29) 1",
                     cursor_x, cursor_y, all_ok);
        end
        sq.delete();
        send(9'h00A);
        @(negedge clk_sys);
        t1 = cyc;
        wait_ready(200, ok);
        checks++;
        if (!ok || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL lf_wrap_cursor: cur=(%0d,%0d) ok=%b, want (0,0) 1",
                     cursor_x, cursor_y, ok);
        end
        bad = 0;
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].x != 7'(i) || sq[i].y != 6'd0 || sq[i].chr != 9'h020
                || sq[i].cyc != t1 + i) bad++;
        end
        checks++;
        if (sq.size() != 80 || bad != 0 || ready_cyc != t1 + 80) begin
            errors++;
            $display("FAIL lf_wrap_clear: strobes=%0d bad=%0d ready_at=%0d, want 80 0 %0d",
                     sq.size(), bad, ready_cyc - t1, 80);
        end
    endtask

    task automatic test_control_codes;
        bit ok;
        int bad;
        for (int i = 0; i < 3; i++) begin
            send(9'h00A);
            wait_ready(200, ok);
        end
        for (int i = 0; i < 5; i++) begin
            send(9'h058);
            wait_ready(20, ok);
        end
        checks++;
        if (cursor_x !== 7'd5 || cursor_y !== 6'd3) begin
            errors++;
            $display("FAIL ctrl_setup: cur=(%0d,%0d), want (5,3)", cursor_x, cursor_y);
        end
        sq.delete();
        send(9'h00D);
        @(negedge clk_sys);
        checks++;
        if (in_ready !== 1'b1 || char_str !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 6'd3) begin
            errors++;
            $display("FAIL ctrl_cr: rdy=%b str=%b cur=(%0d,%0d), want 1 0 (0,3)",
                     in_ready, char_str, cursor_x, cursor_y);
        end
        send(9'h008);
        @(negedge clk_sys);
        checks++;
        if (in_ready !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 6'd3 || sq.size() != 0) begin
            errors++;
            $display("FAIL ctrl_bs_at_zero: rdy=%b cur=(%0d,%0d) strobes=%0d, want 1 (0,3) 0",
                     in_ready, cursor_x, cursor_y, sq.size());
        end
        // Bit 8 set: 0x10A is a glyph, not a line feed.
        send(9'h10A);
        @(negedge clk_sys);
        checks++;
        if (char_str !== 1'b1 || char_chr !== 9'h10A || char_x !== 7'd0 || char_y !== 6'd3) begin
            errors++;
            $display("FAIL ctrl_bit8_glyph: str=%b chr=%h x=%0d y=%0d, want 1 10a 0 3",
                     char_str, char_chr, char_x, char_y);
        end
        wait_ready(20, ok);
        send(9'h008);
        @(negedge clk_sys);
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd3 || sq.size() != 1) begin
            errors++;
            $display("FAIL ctrl_bs: cur=(%0d,%0d) strobes=%0d, want (0,3) 1",
                     cursor_x, cursor_y, sq.size());
        end
        sq.delete();
        send(9'h00C);
        wait_ready(3000, ok);
        bad = 0;
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].x != 7'(i % 80) || sq[i].y != 6'(i / 80) || sq[i].chr != 9'h020) bad++;
        end
        checks++;
        if (!ok || sq.size() != 2400 || bad != 0) begin
            errors++;
            $display("FAIL ctrl_ff_clear: ok=%b strobes=%0d bad=%0d, want 1 2400 0",
                     ok, sq.size(), bad);
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL ctrl_ff_cursor: (%0d,%0d), want (0,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_abort;
        bit ok;
        int bad;
        send(9'h041);
        wait_ready(20, ok);
        sq.delete();
        send(9'h00C);
        repeat (1000) @(negedge clk_sys);
        reset = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (char_str !== 1'b0 || sq.size() != 1000) begin
            errors++;
            $display("FAIL abort_no_strobe: str=%b strobes_before=%0d, want 0 1000",
                     char_str, sq.size());
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0 || char_x !== 7'd0 || char_y !== 6'd0
            || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: cur=(%0d,%0d) x=%0d y=%0d busy=%b, want (0,0) 0 0 1",
                     cursor_x, cursor_y, char_x, char_y, busy);
        end
        sq.delete();
        wait_ready(3000, ok);
        bad = 0;
        for (int i = 0; i < sq.size(); i++) begin
            if (sq[i].x != 7'(i % 80) || sq[i].y != 6'(i / 80) || sq[i].chr != 9'h020) bad++;
        end
        checks++;
        if (!ok || sq.size() != 2400 || bad != 0) begin
            errors++;
            $display("FAIL abort_restart: ok=%b strobes=%0d bad=%0d, want 1 2400 0",
                     ok, sq.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_row_fill();
        test_lf_wrap();
        test_control_codes();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flapjack_console.md
Name: flapjack_console

Overview:
Character-stream console controller that sequences the textmode write port (char_x/char_y/char_chr/char_str). It accepts one character at a time over a valid/ready handshake and maintains a hardware cursor. It interprets control codes and performs row and screen clears as bursts of write strobes. It sits between flapjack_core, or any other character producer, and vga_textmode, so producers do not need to track screen coordinates.

Parameters:
COLS, 80, text columns; 2..128
ROWS, 30, text rows; 2..64
CLEAR_ON_RESET, 1, when 1, perform a full-screen clear after reset
CHR_BLANK, 9'h020, glyph code written by clears

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
in_chr  in  9  character code; control codes are decoded only when in_chr[8]==0
in_valid  in  1  producer has a character
in_ready  out  1  console accepts a character this cycle
char_x  out  7  write column to textmode
char_y  out  6  write row to textmode
char_chr  out  9  glyph to textmode
char_str  out  1  one-cycle write strobe to textmode
cursor_x  out  7  current cursor column
cursor_y  out  6  current cursor row
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk_sys). Reset is synchronous and active-high. All outputs are registered except in_ready and busy, which decode state.
- Reset values: char_x=0, char_y=0, char_chr=0, char_str=0, cursor=(0,0).
- State after reset: CLEAR_ALL if CLEAR_ON_RESET=1, otherwise IDLE.
- Reset asserted mid-burst aborts the burst immediately. No strobe is issued in the cycle after reset is sampled.
- States: IDLE, PUT, CLEAR_ROW, CLEAR_ALL.
- in_ready = (state==IDLE). A transfer occurs when in_valid && in_ready.
- in_chr is captured on transfer. It is never sampled while in_ready is low.
- Printable character (any code not listed below, or in_chr[8]=1):
  - IDLE to PUT. In the PUT cycle (transfer cycle +1): char_str=1, char_x/char_y=cursor before advance, char_chr=captured code.
  - If cursor_x<COLS-1: cursor_x+1, return to IDLE.
  - Otherwise: newline.
  - Throughput is one character per 2 cycles.
- Newline operation:
  - cursor_x=0.
  - cursor_y = (cursor_y==ROWS-1) ? 0 : cursor_y+1. Wrap-around replaces scrolling.
  - Then enter CLEAR_ROW on the new row.
- 0x0A LF: newline operation, with no glyph strobe.
- 0x0D CR: cursor_x=0, no strobe, stay IDLE. in_ready stays high the next cycle.
- 0x08 BS: if cursor_x>0 then cursor_x-1; no strobe; stay IDLE. At x=0: no change.
- 0x0C FF: cursor=(0,0), then CLEAR_ALL.
- CLEAR_ROW:
  - COLS consecutive strobes with char_chr=CHR_BLANK, char_y=new row, char_x=0..COLS-1 ascending.
  - The first strobe is in the cycle after entry. Return to IDLE after the last strobe.
  - Total cost is COLS cycles with in_ready low.
- CLEAR_ALL:
  - ROWS*COLS consecutive strobes of CHR_BLANK, row-major from (0,0) to (COLS-1,ROWS-1).
  - Cursor is (0,0) at exit.
- cursor_x/cursor_y are valid whenever in_ready=1. During bursts they hold the final post-operation position.
- char_x/char_y/char_chr hold their last values when char_str=0.
- Internal counters are sized $clog2 of COLS/ROWS. Compare against COLS-1/ROWS-1 and never rely on natural overflow.

Decomposition:
- Package flapjack_console_pkg: state enum type, control code constants CC_BS=9'h008, CC_LF=9'h00A, CC_FF=9'h00C, CC_CR=9'h00D, and the default CHR_BLANK.
- No sub-module. Cursor and burst counters are local registers in one FSM.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> exactly 2400 strobes, all chr=0x020, row-major; in_ready rises the cycle after strobe (79,29); cursor=(0,0).
- After the clear, send 'A' (0x041) -> single strobe x=0, y=0, chr=0x041 one cycle after transfer; cursor=(1,0); in_ready high 2 cycles after transfer.
- Send 80 printable chars -> 80 glyph strobes on row 0, then 80 blank strobes on row 1; cursor=(0,1).
- Move cursor to row 29, send LF -> cursor=(0,0); 80 blank strobes on row 0; no glyph strobe.
- At cursor (5,3): CR -> (0,3); BS at x=0 -> unchanged, no strobe; FF -> 2400 blank strobes, cursor=(0,0).
- Assert reset for 1 cycle after strobe 1000 of a CLEAR_ALL -> no strobe in the following cycle; restart produces a fresh 2400-strobe clear starting at (0,0).
